// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the coherence bus controller:
// bus FSM states, RAM handshake encoding and block addressing.
package coherence_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    INSTR,
    WB,
    SNOOP,
    C2C,
    RAMREAD
  } bus_state_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int CNT_W = 4;

  // byte address of word idx inside a block starting at base
  function automatic logic [31:0] word_addr(
    input logic [31:0]      base,
    input logic [CNT_W-1:0] idx
  );
    return base + {26'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts one past ptr
// and wraps, returning a one-hot grant and its index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] gidx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  // first requester after ptr, scanning in wrap-around order
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping bus controller: arbitrates instruction and data
// requests from CPUS cache pairs onto one shared RAM port.
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int CPUS  = 4,
  parameter int WORDS = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CPUS-1:0]       iREN,
  output logic [CPUS-1:0]       iwait,
  input  logic [CPUS-1:0][31:0] iaddr,
  output logic [31:0]           iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  output logic [CPUS-1:0]       dwait,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0][31:0] dload,
  input  logic [CPUS-1:0]       cctrans,
  input  logic [CPUS-1:0]       ccwrite,
  output logic [CPUS-1:0]       ccwait,
  output logic [CPUS-1:0]       ccinv,
  output logic [31:0]           ccsnoopaddr,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate
);

  localparam int IW = $clog2(CPUS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  bus_state_t       state, state_n;
  logic [IW-1:0]    dptr, iptr, iwin, sup, sup_n;
  logic [IW-1:0]    dgidx, igidx;
  logic [CPUS-1:0]  dgrant, igrant, dsel, isel;
  logic [CPUS-1:0]  others, wr_resp, rel;
  logic [CNT_W-1:0] cnt;
  logic             access, last_word, snoop_done, sup_found;

  assign access     = (ramstate == ACCESS);
  assign last_word  = (cnt == LAST);
  assign others     = ~dsel;
  assign wr_resp    = ccwrite & others;
  assign snoop_done = &(cctrans | dsel);
  assign rel        = (access && last_word) ? '0 : others;

  rr_arbiter #(.N(CPUS)) u_darb (
    .req   (cctrans | dWEN),
    .ptr   (dptr),
    .grant (dgrant),
    .gidx  (dgidx)
  );

  rr_arbiter #(.N(CPUS)) u_iarb (
    .req   (iREN),
    .ptr   (iptr),
    .grant (igrant),
    .gidx  (igidx)
  );

  // lowest-index responder holding a modified copy
  always_comb begin
    sup_n     = '0;
    sup_found = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      if (!sup_found && wr_resp[i]) begin
        sup_found = 1'b1;
        sup_n     = IW'(i);
      end
    end
  end

  // state, winners, pointers, supplier and word counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      dptr  <= IW'(CPUS - 1);
      iptr  <= IW'(CPUS - 1);
      iwin  <= IW'(CPUS - 1);
      dsel  <= CPUS'(1) << (CPUS - 1);
      isel  <= CPUS'(1) << (CPUS - 1);
      cnt   <= '0;
      sup   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == ARB) begin
        dptr <= dgidx;
        dsel <= dgrant;
      end
      if (state == IDLE && state_n == INSTR) begin
        iwin <= igidx;
        isel <= igrant;
      end
      if (state == INSTR && access)
        iptr <= iwin;
      if (state == SNOOP && state_n == C2C)
        sup <= sup_n;
      if ((state == WB || state == C2C ||
           state == RAMREAD) && access)
        cnt <= last_word ? '0 : cnt + CNT_W'(1);
    end
  end

  // next state and bus outputs; ERROR simply never releases
  always_comb begin
    state_n     = state;
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    dload       = '0;
    iload       = '0;
    unique case (state)
      IDLE: begin
        if (|(cctrans | dWEN))
          state_n = ARB;
        else if (|iREN)
          state_n = INSTR;
      end
      ARB: begin
        if (dWEN[dptr])
          state_n = WB;
        else if (dREN[dptr])
          state_n = SNOOP;
      end
      INSTR: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[iwin];
        iload   = ramload;
        if (access) begin
          iwait   = ~isel;
          state_n = IDLE;
        end
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = word_addr(daddr[dptr], cnt);
        ramstore = dstore[dptr];
        if (access) begin
          dwait = ~dsel;
          if (last_word)
            state_n = IDLE;
        end
      end
      SNOOP: begin
        ccsnoopaddr = daddr[dptr];
        ccwait      = others;
        if (ccwrite[dptr])
          ccinv = others;
        if (snoop_done)
          state_n = sup_found ? C2C : RAMREAD;
      end
      C2C: begin
        ramWEN      = 1'b1;
        ramaddr     = word_addr(daddr[dptr], cnt);
        ramstore    = dstore[sup];
        dload[dptr] = dstore[sup];
        ccwait      = rel;
        if (access) begin
          dwait = ~(dsel | (CPUS'(1) << sup));
          if (last_word)
            state_n = IDLE;
        end
      end
      RAMREAD: begin
        ramREN      = 1'b1;
        ramaddr     = word_addr(daddr[dptr], cnt);
        dload[dptr] = ramload;
        ccwait      = rel;
        if (access) begin
          dwait = ~dsel;
          if (last_word)
            state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl with a transaction
// model checked every cycle plus literal scenario checks.
module tb_coherence_bus_ctrl;
  import coherence_bus_ctrl_pkg::*;

  localparam int CPUS  = 4;
  localparam int WORDS = 2;
  localparam int IW    = $clog2(CPUS);

  localparam int P_IDLE  = 0;
  localparam int P_ARB   = 1;
  localparam int P_FETCH = 2;
  localparam int P_WB    = 3;
  localparam int P_SNOOP = 4;
  localparam int P_C2C   = 5;
  localparam int P_READ  = 6;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [CPUS-1:0]       iREN, iwait, dREN, dWEN, dwait;
  logic [CPUS-1:0]       cctrans, ccwrite, ccwait, ccinv;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore, dload;
  logic [31:0]           iload, ccsnoopaddr;
  logic                  ramREN, ramWEN;
  logic [31:0]           ramaddr, ramstore, ramload;
  logic [1:0]            ramstate;

  coherence_bus_ctrl #(.CPUS(CPUS), .WORDS(WORDS)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iwait(iwait), .iaddr(iaddr), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .dwait(dwait), .daddr(daddr),
    .dstore(dstore), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #10 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // RAM: 2 BUSY cycles then ACCESS; err_left turns ACCESS into ERROR
  int lat = 2;
  int busy_cnt = 0;
  int err_left = 0;
  logic [31:0] serial = 0;
  always @(posedge CLK) begin
    #1;
    serial  = serial + 1;
    ramload = 32'hC0DE_0000 + serial;
    if (!(ramREN || ramWEN)) begin
      busy_cnt = 0;
      ramstate = FREE;
    end else if (busy_cnt < lat) begin
      busy_cnt++;
      ramstate = BUSY;
    end else if (err_left > 0) begin
      err_left--;
      ramstate = ERROR;
    end else begin
      busy_cnt = 0;
      ramstate = ACCESS;
    end
  end

  // transaction model
  int            ph, mword;
  logic [IW-1:0] mw, msup, mlastd, mlasti;
  logic          acc, allresp, supok;

  logic [CPUS-1:0]       e_iwait, e_dwait, e_ccwait, e_ccinv;
  logic [CPUS-1:0][31:0] e_dload;
  logic [31:0]           e_iload, e_snoop, e_ramaddr, e_ramstore;
  logic                  e_ramREN, e_ramWEN;

  int          iq[$];
  logic [31:0] wq[$];
  logic [31:0] wqd[$];

  function automatic logic [IW-1:0] rr_pick(
    input logic [CPUS-1:0] req, input logic [IW-1:0] last);
    for (int k = 1; k <= CPUS; k++)
      if (req[IW'((int'(last) + k) % CPUS)])
        return IW'((int'(last) + k) % CPUS);
    return last;
  endfunction

  always @(negedge CLK) begin
    acc = (ramstate == ACCESS);
    if (RST) begin
      ph = P_IDLE; mword = 0; msup = '0;
      mlastd = IW'(CPUS - 1); mlasti = IW'(CPUS - 1);
    end
    e_iwait = '1; e_dwait = '1; e_ccwait = '0; e_ccinv = '0;
    e_dload = '0; e_iload = '0; e_snoop = '0;
    e_ramaddr = '0; e_ramstore = '0; e_ramREN = 0; e_ramWEN = 0;
    case (ph)
      P_FETCH: begin
        e_ramREN = 1; e_ramaddr = iaddr[mw]; e_iload = ramload;
        if (acc) e_iwait[mw] = 0;
      end
      P_WB: begin
        e_ramWEN = 1; e_ramaddr = daddr[mw] + 32'(mword * 4);
        e_ramstore = dstore[mw];
        if (acc) e_dwait[mw] = 0;
      end
      P_SNOOP: begin
        e_snoop = daddr[mw];
        e_ccwait = '1; e_ccwait[mw] = 0;
        if (ccwrite[mw]) e_ccinv = e_ccwait;
      end
      P_C2C, P_READ: begin
        e_ramaddr = daddr[mw] + 32'(mword * 4);
        if (!(acc && mword == WORDS - 1)) begin
          e_ccwait = '1; e_ccwait[mw] = 0;
        end
        if (ph == P_C2C) begin
          e_ramWEN = 1; e_ramstore = dstore[msup];
          e_dload[mw] = dstore[msup];
          if (acc) e_dwait[msup] = 0;
        end else begin
          e_ramREN = 1; e_dload[mw] = ramload;
        end
        if (acc) e_dwait[mw] = 0;
      end
      default: ;
    endcase
    chk("iwait", 128'(iwait), 128'(e_iwait));
    chk("dwait", 128'(dwait), 128'(e_dwait));
    chk("iload", 128'(iload), 128'(e_iload));
    chk("dload", 128'(dload), 128'(e_dload));
    chk("ccwait", 128'(ccwait), 128'(e_ccwait));
    chk("ccinv", 128'(ccinv), 128'(e_ccinv));
    chk("snoopaddr", 128'(ccsnoopaddr), 128'(e_snoop));
    chk("ramREN", 128'(ramREN), 128'(e_ramREN));
    chk("ramWEN", 128'(ramWEN), 128'(e_ramWEN));
    chk("ramaddr", 128'(ramaddr), 128'(e_ramaddr));
    chk("ramstore", 128'(ramstore), 128'(e_ramstore));
    if (!RST) begin
      for (int i = 0; i < CPUS; i++)
        if (!iwait[IW'(i)]) iq.push_back(i);
      if (ramWEN && acc) begin
        wq.push_back(ramaddr);
        wqd.push_back(ramstore);
      end
      case (ph)
        P_IDLE:
          if (|(cctrans | dWEN)) begin
            mw = rr_pick(cctrans | dWEN, mlastd);
            mlastd = mw; ph = P_ARB;
          end else if (|iREN) begin
            mw = rr_pick(iREN, mlasti); ph = P_FETCH;
          end
        P_ARB:
          if (dWEN[mw]) ph = P_WB;
          else if (dREN[mw]) ph = P_SNOOP;
        P_FETCH:
          if (acc) begin mlasti = mw; ph = P_IDLE; end
        P_SNOOP: begin
          allresp = 1; supok = 0;
          for (int i = 0; i < CPUS; i++)
            if (IW'(i) != mw) begin
              if (!cctrans[IW'(i)]) allresp = 0;
              if (ccwrite[IW'(i)] && !supok) begin
                supok = 1; msup = IW'(i);
              end
            end
          if (allresp) ph = supok ? P_C2C : P_READ;
        end
        default:
          if (acc) begin
            if (mword == WORDS - 1) begin
              mword = 0; ph = P_IDLE;
            end else mword++;
          end
      endcase
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int acc_n, nerr, wsz;

  initial begin
    iREN = 0; dREN = 0; dWEN = 0; cctrans = 0; ccwrite = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
    step(); step();
    chk("rst_iwait", 128'(iwait), 128'(4'hF));
    chk("rst_dwait", 128'(dwait), 128'(4'hF));
    chk("rst_ram", 128'({ramREN, ramWEN}), 128'(2'b00));
    RST = 0;
    step();

    // four fetchers, round-robin from CPU0
    for (int i = 0; i < CPUS; i++)
      iaddr[i] = 32'h1000 + 32'(i * 16);
    iREN = 4'hF;
    for (int t = 0; t < 200 && iq.size() < 5; t++) step();
    iREN = 0;
    chk("fetch_count", 128'(iq.size()), 128'(5));
    for (int k = 0; k < iq.size() && k < 5; k++)
      chk("fetch_order", 128'(iq[k]), 128'(exp_order[k]));
    step();

    // write-back beats a simultaneous fetch
    iq.delete(); wq.delete(); wqd.delete();
    daddr[2] = 32'h2000; dstore[2] = 32'h1111_2222;
    dWEN = 4'b0100; iREN = 4'b0001;
    for (int t = 0; t < 100 && wq.size() < 2; t++) step();
    dWEN = 0;
    chk("wb_before_fetch", 128'(iq.size()), 128'(0));
    for (int t = 0; t < 100 && iq.size() < 1; t++) step();
    iREN = 0;
    chk("wb_writes", 128'(wq.size()), 128'(2));
    if (wq.size() >= 2) begin
      chk("wb_addr0", 128'(wq[0]), 128'(32'h2000));
      chk("wb_addr1", 128'(wq[1]), 128'(32'h2004));
      chk("wb_data", 128'(wqd[1]), 128'(32'h1111_2222));
    end
    chk("fetch_after_wb", 128'(iq.size()), 128'(1));
    if (iq.size() > 0) chk("fetch_cpu0", 128'(iq[0]), 128'(0));
    step();

    // CPU1 read, CPU3 supplies modified data
    daddr[1] = 32'h100; cctrans = 4'b0010; dREN = 4'b0010;
    for (int t = 0; t < 50 && ccwait != 4'b1101; t++) step();
    chk("c2c_snoop", 128'(ccwait), 128'(4'b1101));
    chk("c2c_snpaddr", 128'(ccsnoopaddr), 128'(32'h100));
    cctrans = 4'b1111; ccwrite = 4'b1000; dstore[3] = 32'hDEAD;
    acc_n = 0;
    for (int t = 0; t < 60 && acc_n < 2; t++) begin
      step();
      if (ramstate == ACCESS && ramWEN) begin
        acc_n++;
        if (acc_n == 1) begin
          chk("c2c_dload", 128'(dload[1]), 128'(32'hDEAD));
          chk("c2c_ramaddr", 128'(ramaddr), 128'(32'h100));
          chk("c2c_store", 128'(ramstore), 128'(32'hDEAD));
          chk("c2c_dwait", 128'(dwait), 128'(4'b0101));
          chk("c2c_ccwait", 128'(ccwait), 128'(4'b1101));
        end else
          chk("c2c_ccrel", 128'(ccwait), 128'(4'b0000));
      end
    end
    chk("c2c_words", 128'(acc_n), 128'(2));
    step();
    cctrans = 0; ccwrite = 0; dREN = 0;
    step();

    // CPU0 read, nobody modified: from RAM
    daddr[0] = 32'h300; cctrans = 4'b0001; dREN = 4'b0001;
    for (int t = 0; t < 50 && ccwait != 4'b1110; t++) step();
    chk("rd_snoop", 128'(ccwait), 128'(4'b1110));
    cctrans = 4'b1111;
    acc_n = 0;
    for (int t = 0; t < 60 && acc_n < 2; t++) begin
      step();
      if (ramstate == ACCESS && ramREN) begin
        acc_n++;
        chk("rd_dload", 128'(dload[0]), 128'(ramload));
        chk("rd_dwait", 128'(dwait), 128'(4'b1110));
        chk("rd_ccwait", 128'(ccwait),
            128'(acc_n == 2 ? 4'b0000 : 4'b1110));
        chk("rd_addr", 128'(ramaddr),
            128'(32'h300 + 32'((acc_n - 1) * 4)));
      end
    end
    chk("rd_words", 128'(acc_n), 128'(2));
    step();
    cctrans = 0; dREN = 0;
    step();

    // RAM errors in the middle of a write-back
    wq.delete(); wqd.delete();
    daddr[1] = 32'h400; dstore[1] = 32'h5555_AAAA; dWEN = 4'b0010;
    nerr = 0; acc_n = 0;
    for (int t = 0; t < 100 && wq.size() < 2; t++) begin
      step();
      if (wq.size() == 1 && acc_n == 0) begin
        err_left = 3; acc_n = 1;
      end
      if (ramstate == ERROR && ramWEN) begin
        nerr++;
        chk("err_dwait", 128'(dwait), 128'(4'hF));
        chk("err_addr", 128'(ramaddr), 128'(32'h404));
      end
    end
    dWEN = 0;
    chk("err_cycles", 128'(nerr), 128'(3));
    chk("err_writes", 128'(wq.size()), 128'(2));
    if (wq.size() >= 2) begin
      chk("err_addr0", 128'(wq[0]), 128'(32'h400));
      chk("err_addr1", 128'(wq[1]), 128'(32'h404));
      chk("err_data", 128'(wqd[1]), 128'(32'h5555_AAAA));
    end
    step(); step();

    // reset pulse in the middle of a cache-to-cache transfer
    daddr[2] = 32'h500; cctrans = 4'b0100; dREN = 4'b0100;
    for (int t = 0; t < 50 && ccwait != 4'b1011; t++) step();
    chk("rst_snoop", 128'(ccwait), 128'(4'b1011));
    cctrans = 4'b1111; ccwrite = 4'b0001; dstore[0] = 32'hBEEF;
    for (int t = 0; t < 50 && !(ramWEN && ramstate == BUSY); t++)
      step();
    chk("rst_in_c2c", 128'(ramWEN), 128'(1));
    wsz = wq.size();
    #3;
    RST = 1;
    #1;
    chk("rst_mid_iwait", 128'(iwait), 128'(4'hF));
    chk("rst_mid_dwait", 128'(dwait), 128'(4'hF));
    chk("rst_mid_wen", 128'(ramWEN), 128'(0));
    chk("rst_mid_ccwait", 128'(ccwait), 128'(4'b0000));
    chk("rst_mid_dload", 128'(dload), 128'(0));
    cctrans = 0; ccwrite = 0; dREN = 0;
    step();
    RST = 0;
    for (int t = 0; t < 6; t++) step();
    chk("rst_no_write", 128'(wq.size()), 128'(wsz));

    // data pointer restarts at CPU0 after reset
    wq.delete(); wqd.delete();
    daddr[0] = 32'h600; daddr[3] = 32'h700; dWEN = 4'b1001;
    for (int t = 0; t < 100 && wq.size() < 2; t++) step();
    dWEN = 0;
    chk("post_rst_writes", 128'(wq.size()), 128'(2));
    if (wq.size() >= 2) begin
      chk("post_rst_a0", 128'(wq[0]), 128'(32'h600));
      chk("post_rst_a1", 128'(wq[1]), 128'(32'h604));
    end
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

Interface
REQ-001 SHALL have parameter CPUS, default 4, number of cache pairs; legal range 2..8.
REQ-002 SHALL have parameter WORDS, default 2, words per data block; power of two, 1..8.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports iREN/iwait  in/out  CPUS  per-CPU instruction request and stall; iaddr  in  CPUS x 32; iload  out  32, shared across CPUs.
REQ-006 SHALL have ports dREN/dWEN  in  CPUS; dwait  out  CPUS; daddr/dstore  in  CPUS x 32; dload  out  CPUS x 32.
REQ-007 SHALL have ports cctrans/ccwrite  in  CPUS; ccwait/ccinv  out  CPUS; ccsnoopaddr  out  32, broadcast.
REQ-008 SHALL have ports ramREN/ramWEN  out  1; ramaddr/ramstore  out  32; ramload  in  32; ramstate  in  2 (FREE, BUSY, ACCESS, ERROR).

Function
REQ-009 SHALL implement FSM states IDLE, ARB, INSTR, WB, SNOOP, C2C, RAMREAD.
REQ-010 In IDLE, any cctrans or dWEN SHALL win over iREN: next state ARB. Otherwise any iREN: next state INSTR.
REQ-011 Data grant SHALL be round-robin: search starts at the CPU after the last data winner. Pointer dptr SHALL update only on entry to ARB.
REQ-012 Instruction grant SHALL be round-robin via a separate pointer iptr. iptr SHALL advance past the winner only on the ACCESS cycle that completes the fetch.
REQ-013 In INSTR, the controller SHALL drive ramREN=1 and ramaddr=iaddr[winner], and SHALL drive iload=ramload. It SHALL deassert iwait[winner] only in the cycle ramstate==ACCESS, then return to IDLE.
REQ-014 In ARB, a winner with dWEN SHALL go to WB. A winner with dREN SHALL go to SNOOP. Otherwise the controller SHALL stay in ARB.
REQ-015 In WB, the controller SHALL write WORDS consecutive words from dstore/daddr[winner]. A word counter SHALL advance on each ACCESS cycle. dwait[winner] SHALL be 0 for exactly that cycle. After the last word, next state IDLE.
REQ-016 In SNOOP:
  - ccsnoopaddr SHALL equal daddr[winner].
  - ccwait SHALL be 1 for every non-winner.
  - ccinv SHALL be 1 for every non-winner while ccwrite[winner]=1.
REQ-017 SNOOP SHALL leave once every non-winner asserts cctrans. If any responder has ccwrite=1, the lowest-index such responder is the supplier and next state is C2C. Otherwise next state is RAMREAD.
REQ-018 In C2C:
  - dload[winner] SHALL equal dstore[supplier].
  - RAM SHALL be written with dstore[supplier] at daddr[winner].
  - Each ACCESS cycle SHALL clear dwait for both winner and supplier for one cycle.
  - After WORDS words: next state IDLE, all ccwait deasserted in that final ACCESS cycle.
REQ-019 In RAMREAD, the controller SHALL drive ramREN=1 and dload[winner]=ramload for WORDS words, with the same counter, dwait and ccwait release rules as C2C.
REQ-020 ramstate==ERROR in any RAM-access state SHALL hold the state and word counter and keep all waits asserted, so the access is retried.
REQ-021 ramREN and ramWEN SHALL never be 1 simultaneously. In IDLE, ARB and SNOOP both SHALL be 0.
REQ-022 All outputs not named for the current state SHALL take defaults: waits=all-ones, ccwait/ccinv=0, ram*=0, dload/iload=0.
REQ-023 Requests appearing or dropping mid-transaction SHALL NOT alter the winner until return to IDLE.

Reset
REQ-024 RST SHALL force asynchronously: state=IDLE, dptr=CPUS-1, iptr=CPUS-1, word counter=0, supplier=0.
REQ-025 During and after reset, outputs SHALL equal REQ-022 defaults. An in-flight transaction SHALL be abandoned without completion signalling.

Structure
REQ-026 The state enum and the ramstate encoding SHALL reside in the shared CPU types package.
REQ-027 A sub-module rr_arbiter (params N; inputs req, ptr; outputs grant one-hot, gidx) SHALL be instantiated twice, once for data and once for instruction.

Verification
REQ-028 Bench SHALL cover: CPUS=4; iREN=4'b1111, RAM ACCESS after 2 BUSY cycles -> grants in order 0,1,2,3,0; iwait drops once per fetch.
REQ-029 Bench SHALL cover: dWEN[2] and iREN[0] raised together -> WB serves CPU2 first, 2 RAM writes with addresses A and A+4; then INSTR serves CPU0.
REQ-030 Bench SHALL cover: dREN[1], daddr=0x100; CPU3 replies cctrans=1, ccwrite=1, dstore=0xDEAD -> C2C; dload[1]=0xDEAD; RAM write to 0x100; dwait[1] and dwait[3] low on ACCESS.
REQ-031 Bench SHALL cover: dREN[0] with no modified responder -> RAMREAD; dload[0]=ramload for 2 words; ccwait released on the last ACCESS.
REQ-032 Bench SHALL cover: ramstate=ERROR for 3 cycles mid-WB -> counter holds, word retried, total still 2 writes.
REQ-033 Bench SHALL cover: RST pulsed mid-C2C -> IDLE in the same cycle; all waits=1; ramWEN=0.
